// File: rtl/accum_unit_pkg.sv
// Shared opcode and state definitions for the accumulator stage.
package accum_unit_pkg;

  localparam logic [1:0] OP_CLR  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_ADDC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_add_n.sv
// WIDTH-bit ripple-carry adder chained from full-adder cells.
module ripple_add_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  // One cell per bit; carry ripples from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/accum_unit.sv
// Handshaked accumulator: IDLE accepts an op, EXEC updates the sum, RESP
// holds the result until the consumer takes it.
module accum_unit
  import accum_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             ovf_sticky
);

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] acc;
  logic             carry_reg;

  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Only ADDC chains in the carry left by the previous operation.
  assign add_cin = (op_q == OP_ADDC) & carry_reg;

  ripple_add_n #(.WIDTH(WIDTH)) u_add (
    .a    (acc),
    .b    (data_q),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result and carry come straight from the state registers, stable in RESP.
  assign out_sum  = acc;
  assign out_cout = carry_reg;

  // Control FSM plus accumulator, carry and sticky-overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= OP_CLR;
      data_q     <= '0;
      acc        <= '0;
      carry_reg  <= 1'b0;
      ovf_sticky <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= in_op;
            data_q   <= in_data;
            in_ready <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_CLR: begin
              acc        <= '0;
              carry_reg  <= 1'b0;
              ovf_sticky <= 1'b0;
            end
            OP_LOAD: begin
              acc       <= data_q;
              carry_reg <= 1'b0;
            end
            default: begin
              acc        <= (SATURATE && add_cout) ? '1 : add_sum;
              carry_reg  <= add_cout;
              ovf_sticky <= ovf_sticky | add_cout;
            end
          endcase
          out_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_unit.sv
// Bench for accum_unit: a wrapping and a saturating instance share stimulus
// and are checked against a plain-arithmetic model of the accumulator.
module tb_accum_unit;

  localparam int unsigned W = 4;
  localparam logic [1:0] CLR = 2'd0, LOAD = 2'd1, ADD = 2'd2, ADDC = 2'd3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   in_op;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready0, out_valid0, out_cout0, ovf0;
  logic [W-1:0] out_sum0;
  logic         in_ready1, out_valid1, out_cout1, ovf1;
  logic [W-1:0] out_sum1;

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance: index 0 wraps, index 1 saturates.
  int m_acc   [2];
  int m_carry [2];
  int m_ovf   [2];

  accum_unit #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid0),
    .out_ready(out_ready), .out_sum(out_sum0), .out_cout(out_cout0),
    .ovf_sticky(ovf0)
  );

  accum_unit #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sum(out_sum1), .out_cout(out_cout1),
    .ovf_sticky(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_carry[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // Apply one operation to both model copies; returns {sum, cout, ovf}.
  task automatic model_step(input logic [1:0] op, input int data,
                            output logic [5:0] e0, output logic [5:0] e1);
    logic [5:0] e [2];
    for (int k = 0; k < 2; k++) begin
      int s;
      int c;
      c = 0;
      if (op == CLR) begin
        m_acc[k] = 0; m_carry[k] = 0; m_ovf[k] = 0;
      end else if (op == LOAD) begin
        m_acc[k] = data; m_carry[k] = 0;
      end else begin
        s = m_acc[k] + data + ((op == ADDC) ? m_carry[k] : 0);
        c = (s >= (1 << W)) ? 1 : 0;
        m_carry[k] = c;
        if (c == 1) m_ovf[k] = 1;
        if (k == 1 && c == 1) m_acc[k] = (1 << W) - 1;
        else m_acc[k] = s % (1 << W);
      end
      e[k] = {4'(m_acc[k]), 1'(c), 1'(m_ovf[k])};
    end
    e0 = e[0];
    e1 = e[1];
  endtask

  // Drive one op with out_ready=1; return observed outputs and latency.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] data,
                        output logic [5:0] o0, output logic [5:0] o1,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; in_op = op; in_data = data; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_op = 2'($urandom); in_data = W'($urandom);
    lat = 1;
    while (!out_valid0 && lat < 20) begin
      @(negedge clk);
      lat++;
      in_data = W'($urandom);
    end
    o0 = {out_sum0, out_cout0, ovf0};
    o1 = {out_sum1, out_cout1, ovf1};
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({out_valid0, out_sum0, out_cout0, ovf0, out_valid1, out_sum1, out_cout1, ovf1} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got w=%b/%h/%b/%b s=%b/%h/%b/%b, want all zero",
               out_valid0, out_sum0, out_cout0, ovf0, out_valid1, out_sum1, out_cout1, ovf1);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_vec++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b%b want 11", in_ready0, in_ready1);
    end
  endtask

  task automatic test_load_add();
    logic [1:0] ops [2] = '{LOAD, ADD};
    int         dat [2] = '{5, 3};
    logic [5:0] o0, o1, e0, e1;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], W'(dat[i]), o0, o1, lat);
      model_step(ops[i], dat[i], e0, e1);
      n_vec++;
      if (o0 !== e0 || o1 !== e1) begin
        n_err++;
        $display("FAIL load_add[%0d]: got %h/%h want %h/%h", i, o0, o1, e0, e1);
      end
      n_vec++;
      if (lat != 2) begin
        n_err++;
        $display("FAIL load_add_latency[%0d]: got %0d want 2", i, lat);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] ops [3] = '{LOAD, ADD, ADDC};
    int         dat [3] = '{15, 1, 0};
    logic [5:0] o0, o1, e0, e1;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], W'(dat[i]), o0, o1, lat);
      model_step(ops[i], dat[i], e0, e1);
      n_vec++;
      if (o0 !== e0 || o1 !== e1) begin
        n_err++;
        $display("FAIL wrap[%0d]: got %h/%h want %h/%h", i, o0, o1, e0, e1);
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] ops [3] = '{LOAD, ADD, CLR};
    int         dat [3] = '{14, 3, 9};
    logic [5:0] o0, o1, e0, e1;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], W'(dat[i]), o0, o1, lat);
      model_step(ops[i], dat[i], e0, e1);
      n_vec++;
      if (o0 !== e0 || o1 !== e1) begin
        n_err++;
        $display("FAIL saturate[%0d]: got %h/%h want %h/%h", i, o0, o1, e0, e1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] e0, e1;
    int d;
    int guard;
    d = int'($urandom_range(0, 15));
    in_valid = 1'b1; in_op = ADD; in_data = W'(d); out_ready = 1'b0;
    model_step(ADD, d, e0, e1);
    @(negedge clk);
    guard = 0;
    while (!out_valid0 && guard < 20) begin
      in_op = 2'($urandom); in_data = W'($urandom);
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1 || in_ready0 !== 1'b0 || in_ready1 !== 1'b0 ||
          {out_sum0, out_cout0, ovf0} !== e0 || {out_sum1, out_cout1, ovf1} !== e1) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: got v=%b%b r=%b%b %h/%h want v=11 r=00 %h/%h",
                 c, out_valid0, out_valid1, in_ready0, in_ready1,
                 {out_sum0, out_cout0, ovf0}, {out_sum1, out_cout1, ovf1}, e0, e1);
      end
      in_op = 2'($urandom); in_data = W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid0, out_valid1, in_ready0, in_ready1} !== 4'b0011) begin
      n_err++;
      $display("FAIL backpressure_release: got v=%b%b r=%b%b want v=00 r=11",
               out_valid0, out_valid1, in_ready0, in_ready1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [4];
    int         dat [4];
    logic [5:0] exp0 [$], exp1 [$], got0 [$], got1 [$];
    logic [5:0] e0, e1;
    int         when [$];
    int idx, cyc;
    bit pending;
    for (int i = 0; i < 4; i++) begin
      ops[i] = (i == 0) ? LOAD : ((($urandom & 1) != 0) ? ADD : ADDC);
      dat[i] = int'($urandom_range(0, 15));
    end
    idx = 0; pending = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = ops[0]; in_data = W'(dat[0]);
    for (cyc = 0; cyc < 40; cyc++) begin
      if (pending) begin
        pending = 0;
        if (idx < 4) begin
          in_op = ops[idx]; in_data = W'(dat[idx]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid0) begin
        got0.push_back({out_sum0, out_cout0, ovf0});
        got1.push_back({out_sum1, out_cout1, ovf1});
        when.push_back(cyc);
      end
      if (in_valid && in_ready0) begin
        model_step(ops[idx], dat[idx], e0, e1);
        exp0.push_back(e0); exp1.push_back(e1);
        idx++;
        pending = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++;
    if (got0.size() != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results want 4", got0.size());
    end
    for (int i = 0; i < 4 && i < got0.size(); i++) begin
      n_vec++;
      if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) begin
        n_err++;
        $display("FAIL b2b_value[%0d]: got %h/%h want %h/%h", i, got0[i], got1[i], exp0[i], exp1[i]);
      end
      if (i > 0) begin
        n_vec++;
        if (when[i] - when[i-1] != 3) begin
          n_err++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles want 3", i, when[i] - when[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] o0, o1, e0, e1;
    logic [1:0] op;
    int d, lat;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 3));
      d = int'($urandom_range(0, 15));
      run_op(op, W'(d), o0, o1, lat);
      model_step(op, d, e0, e1);
      n_vec++;
      if (o0 !== e0 || o1 !== e1 || lat != 2) begin
        n_err++;
        $display("FAIL random[%0d] op=%0d d=%0d: got %h/%h lat %0d want %h/%h lat 2",
                 i, op, d, o0, o1, lat, e0, e1);
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] o0, o1, e0, e1;
    int lat;
    run_op(LOAD, 4'd15, o0, o1, lat);
    model_step(LOAD, 15, e0, e1);
    run_op(ADD, 4'd1, o0, o1, lat);
    model_step(ADD, 1, e0, e1);
    n_vec++;
    if ({ovf0, ovf1} !== 2'b11) begin
      n_err++;
      $display("FAIL abort_pre_ovf: got %b%b want 11", ovf0, ovf1);
    end
    in_valid = 1'b1; in_op = ADD; in_data = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid0, out_sum0, ovf0, out_valid1, out_sum1, ovf1} !== 12'd0) begin
      n_err++;
      $display("FAIL abort_immediate: got %b/%h/%b %b/%h/%b want zeros",
               out_valid0, out_sum0, ovf0, out_valid1, out_sum1, ovf1);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if ({out_valid0, out_valid1, in_ready0, in_ready1} !== 4'b0011) begin
        n_err++;
        $display("FAIL abort_after[%0d]: got v=%b%b r=%b%b want v=00 r=11",
                 c, out_valid0, out_valid1, in_ready0, in_ready1);
      end
    end
    run_op(ADD, 4'd2, o0, o1, lat);
    model_step(ADD, 2, e0, e1);
    n_vec++;
    if (o0 !== e0 || o1 !== e1) begin
      n_err++;
      $display("FAIL abort_resume: got %h/%h want %h/%h", o0, o1, e0, e1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_data = '0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_load_add();
    test_wrap();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
